// File: rtl/ttl_counter_sequencer.sv
// Sequencing glue for one 74163-style synchronous counter stage, used as a
// programmable interval timer with optional auto-reload for periodic ticks.
module ttl_counter_sequencer #(
    parameter int WIDTH      = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Length,
    input  logic             Reload,
    input  logic             Hold,
    input  logic             Abort,
    input  logic             RCO,
    output logic             Clear_bar,
    output logic             Load_bar,
    output logic             ENT,
    output logic             ENP,
    output logic [WIDTH-1:0] D,
    output logic             Busy,
    output logic             Done,
    output logic             Tick
);

    // The delay parameters only shape the behavioural gate models; here they
    // are validated so a bad value is caught at elaboration.
    if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
        $error("ttl_counter_sequencer: delays must be non-negative");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE,
        S_CLEAR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] preset;
    logic             reload_tick;
    logic             terminal;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            preset      <= '0;
            reload_tick <= 1'b0;
        end else begin
            state       <= state_next;
            reload_tick <= terminal & Reload & ~Abort;
            if (state == S_IDLE && Start) begin
                // Loading 2^WIDTH - N makes RCO fire after exactly N counts.
                preset <= '0 - Length;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        Clear_bar  = 1'b1;
        Load_bar   = 1'b1;
        ENT        = 1'b0;
        ENP        = 1'b0;
        Busy       = 1'b0;
        terminal   = 1'b0;

        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                Load_bar   = 1'b0;
                Busy       = 1'b1;
                state_next = Abort ? S_CLEAR : S_COUNT;
            end
            S_COUNT: begin
                ENT      = 1'b1;
                ENP      = ~Hold;
                Busy     = 1'b1;
                terminal = RCO & ~Hold;
                // Reloading on the terminal edge keeps the period at N, not N+1.
                if (terminal && Reload) begin
                    Load_bar = 1'b0;
                end
                if (Abort) begin
                    state_next = S_CLEAR;
                end else if (terminal && !Reload) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            S_CLEAR: begin
                Clear_bar  = 1'b0;
                Busy       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Clearing the stage alongside our own reset keeps the two in step.
        if (Reset) begin
            Clear_bar = 1'b0;
        end
    end

    assign D    = preset;
    assign Done = (state == S_DONE);
    assign Tick = Done | reload_tick;

endmodule

// File: tb/tb_ttl_counter_sequencer.sv
// Bench for ttl_counter_sequencer: a behavioural 74163 stage closes the loop,
// directed tables cover the key sequences, random stimulus runs against a model.
module tb_ttl_counter_sequencer;

    localparam int W = 3;
    localparam int M = 1 << W;

    logic         clk;
    logic         reset, start, reload, hold, abort;
    logic [W-1:0] length;
    logic         rco, clear_bar, load_bar, ent, enp, busy, done, tick;
    logic [W-1:0] d;
    logic [W-1:0] q;

    int checks   = 0;
    int failures = 0;

    ttl_counter_sequencer #(.WIDTH(W), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Length(length),
        .Reload(reload), .Hold(hold), .Abort(abort), .RCO(rco),
        .Clear_bar(clear_bar), .Load_bar(load_bar), .ENT(ent), .ENP(enp),
        .D(d), .Busy(busy), .Done(done), .Tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 74163 stage: clear beats load beats count; RCO gated by ENT.
    always @(posedge clk) begin
        if (!clear_bar)     q <= '0;
        else if (!load_bar) q <= d;
        else if (ent && enp) q <= q + W'(1);
    end
    assign rco = ent && (q == '1);

    // Reference model: interval phase plus a count of remaining counting edges.
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_FIN = 3, PH_CLR = 4;
    int m_phase  = PH_IDLE;
    int m_preset = 0;
    int m_n      = 0;
    int m_rem    = 0;
    bit m_tick   = 1'b0;

    typedef struct {
        bit rst, st; int len; bit rl, hd, ab;
        bit busy, done, tick, ldb; int d, q;
    } vec_t;
    vec_t tab[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit rst, st, input int len, input bit rl, hd, ab);
        @(negedge clk);
        reset = rst; start = st; length = len[W-1:0];
        reload = rl; hold = hd; abort = ab;
        #1;
        check("busy",      int'(busy),      int'(m_phase == PH_LOAD || m_phase == PH_RUN || m_phase == PH_CLR));
        check("done",      int'(done),      int'(m_phase == PH_FIN));
        check("tick",      int'(tick),      int'(m_phase == PH_FIN || m_tick));
        check("d",         int'(d),         m_preset);
        check("clear_bar", int'(clear_bar), int'(!(rst || m_phase == PH_CLR)));
        check("load_bar",  int'(load_bar),
              int'(!(m_phase == PH_LOAD || (m_phase == PH_RUN && m_rem == 1 && !hd && rl))));
        check("ent",       int'(ent),       int'(m_phase == PH_RUN));
        check("enp",       int'(enp),       int'(m_phase == PH_RUN && !hd));
    endtask

    task automatic advance();
        int len_i;
        @(posedge clk);
        len_i = int'(length);
        if (reset) begin
            m_phase = PH_IDLE; m_preset = 0; m_tick = 1'b0;
        end else begin
            m_tick = 1'b0;
            case (m_phase)
                PH_IDLE: if (start) begin
                    m_preset = (M - len_i) % M;
                    m_n      = (len_i == 0) ? M : len_i;
                    m_phase  = PH_LOAD;
                end
                PH_LOAD: if (abort) m_phase = PH_CLR;
                         else begin m_phase = PH_RUN; m_rem = m_n; end
                PH_RUN: if (abort) m_phase = PH_CLR;
                        else if (!hold) begin
                            m_rem--;
                            if (m_rem == 0) begin
                                if (reload) begin m_tick = 1'b1; m_rem = m_n; end
                                else m_phase = PH_FIN;
                            end
                        end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    task automatic cyc(input bit rst, st, input int len, input bit rl, hd, ab);
        apply(rst, st, len, rl, hd, ab);
        advance();
    endtask

    task automatic add(input bit rst, st, input int len, input bit rl, hd, ab,
                       input bit b, dn, tk, lb, input int dv, qv);
        vec_t v;
        v.rst = rst; v.st = st; v.len = len; v.rl = rl; v.hd = hd; v.ab = ab;
        v.busy = b; v.done = dn; v.tick = tk; v.ldb = lb; v.d = dv; v.q = qv;
        tab.push_back(v);
    endtask

    // Start an interval and return the cycle index (LOAD = 0) where Done appears.
    task automatic measure(input int len, input int hold_from, input int hold_cnt,
                           output int done_idx, output bit rco_held);
        done_idx = -1;
        rco_held = 1'b0;
        cyc(0, 1, len, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            bit h;
            h = (i >= hold_from) && (i < hold_from + hold_cnt);
            apply(0, 0, len, 0, h, 0);
            if (h && i == hold_from + hold_cnt - 1) rco_held = rco;
            if (done && done_idx < 0) done_idx = i;
            advance();
            if (done_idx >= 0) break;
        end
    endtask

    initial begin
        int idx;
        bit rh;

        // One-shot, Length=3: D=5, Q 5,6,7,0, Done 4 edges after Start.
        add(1,0,0,0,0,0, 0,0,0,1,0,0);
        add(0,1,3,0,0,0, 0,0,0,1,0,0);
        add(0,0,3,0,0,0, 1,0,0,0,5,0);
        add(0,0,3,0,0,0, 1,0,0,1,5,5);
        add(0,0,3,0,0,0, 1,0,0,1,5,6);
        add(0,0,3,0,0,0, 1,0,0,1,5,7);
        add(0,0,3,0,0,0, 0,1,1,1,5,0);
        add(0,0,3,0,0,0, 0,0,0,1,5,0);
        // Auto-reload, Length=3: Load_bar low only in RCO cycles, Done at end.
        add(0,1,3,1,0,0, 0,0,0,1,5,0);
        add(0,0,3,1,0,0, 1,0,0,0,5,0);
        for (int p = 0; p < 2; p++) begin
            add(0,0,3,1,0,0, 1,0,p != 0,1,5,5);
            add(0,0,3,1,0,0, 1,0,0,1,5,6);
            add(0,0,3,1,0,0, 1,0,0,0,5,7);
        end
        add(0,0,3,0,0,0, 1,0,1,1,5,5);
        add(0,0,3,0,0,0, 1,0,0,1,5,6);
        add(0,0,3,0,0,0, 1,0,0,1,5,7);
        add(0,0,3,0,0,0, 0,1,1,1,5,0);
        add(0,0,3,0,0,0, 0,0,0,1,5,0);

        reset = 1'b1; start = 1'b0; length = '0;
        reload = 1'b0; hold = 1'b0; abort = 1'b0;
        advance();

        foreach (tab[i]) begin
            apply(tab[i].rst, tab[i].st, tab[i].len, tab[i].rl, tab[i].hd, tab[i].ab);
            check($sformatf("tab%0d_busy", i), int'(busy), int'(tab[i].busy));
            check($sformatf("tab%0d_done", i), int'(done), int'(tab[i].done));
            check($sformatf("tab%0d_tick", i), int'(tick), int'(tab[i].tick));
            check($sformatf("tab%0d_load_bar", i), int'(load_bar), int'(tab[i].ldb));
            check($sformatf("tab%0d_d", i), int'(d), tab[i].d);
            check($sformatf("tab%0d_q", i), int'(q), tab[i].q);
            advance();
        end

        // Interval lengths, boundaries and Hold through the RCO cycle.
        measure(1, 100, 0, idx, rh);
        check("len1_done_idx", idx, 2);
        apply(0, 0, 0, 0, 0, 0); check("len1_d", int'(d), 7); advance();
        measure(0, 100, 0, idx, rh);
        check("len0_done_idx", idx, 9);
        apply(0, 0, 0, 0, 0, 0); check("len0_d", int'(d), 0); advance();
        measure(3, 3, 3, idx, rh);
        check("hold_done_idx", idx, 7);
        check("hold_rco_high", int'(rh), 1);
        check("hold_q_frozen", int'(q), 0);

        // Abort at Q=6: one CLEAR cycle, stage cleared, no Done.
        cyc(0, 1, 3, 0, 0, 0);
        cyc(0, 0, 3, 0, 0, 0);
        cyc(0, 0, 3, 0, 0, 0);
        apply(0, 0, 3, 0, 0, 1); check("abort_q_at6", int'(q), 6); advance();
        apply(0, 0, 3, 0, 0, 0);
        check("abort_clear_bar", int'(clear_bar), 0);
        check("abort_done", int'(done), 0);
        advance();
        apply(0, 0, 3, 0, 0, 0);
        check("abort_q_cleared", int'(q), 0);
        check("abort_busy_idle", int'(busy), 0);
        advance();

        // Abort on the terminal edge still suppresses Done and Tick.
        cyc(0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 3, 0, 0, 0);
        apply(0, 0, 3, 0, 0, 1); check("abort_term_rco", int'(rco), 1); advance();
        apply(0, 0, 3, 0, 0, 0);
        check("abort_term_done", int'(done), 0);
        check("abort_term_tick", int'(tick), 0);
        advance();
        cyc(0, 0, 3, 0, 0, 0);

        // Start while busy is ignored; Reset mid-count returns to idle.
        cyc(0, 1, 3, 0, 0, 0);
        cyc(0, 1, 5, 0, 0, 0);
        cyc(0, 1, 6, 0, 0, 0);
        apply(1, 1, 6, 0, 0, 0);
        check("busy_start_d", int'(d), 5);
        check("reset_clear_bar", int'(clear_bar), 0);
        advance();
        apply(0, 0, 6, 0, 0, 0);
        check("reset_busy", int'(busy), 0);
        check("reset_q", int'(q), 0);
        check("reset_d", int'(d), 0);
        advance();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, M - 1)), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ttl_counter_sequencer.md
Name: ttl_counter_sequencer

Overview:
- Synchronous controller that drives one 74163-style counter stage as a programmable interval timer.
- Drives the stage's Clear_bar, Load_bar, ENT, ENP and D, and watches its RCO.
- A requester issues Start with a Length; the block loads the stage, counts Length clocks, then reports Done.
- Optional auto-reload gives a periodic Tick. Sits beside the 7400-series counter models as their sequencing glue.

Parameters:
- WIDTH, 4, counter stage width in bits (D, Length).
- DELAY_RISE, 0, output rise delay in ns.
- DELAY_FALL, 0, output fall delay in ns.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a new interval; sampled only in IDLE.
- Length  input  WIDTH  interval length N; 0 means 2^WIDTH; latched when Start is accepted.
- Reload  input  1  live input, sampled at terminal edge: 1 = reload and continue, 0 = finish.
- Hold  input  1  pause counting while high (COUNT state only).
- Abort  input  1  cancel an interval in progress.
- RCO  input  1  ripple carry from the counter stage.
- Clear_bar  output  1  to stage; low = synchronous clear.
- Load_bar  output  1  to stage; low = parallel load.
- ENT  output  1  to stage count enable T.
- ENP  output  1  to stage count enable P.
- D  output  WIDTH  preset value to stage.
- Busy  output  1  interval in progress.
- Done  output  1  one-cycle pulse at end of a one-shot or final interval.
- Tick  output  1  one-cycle pulse after every terminal count.

Behaviour:
- States: IDLE, LOAD, COUNT, DONE, CLEAR. Registered state; counter-control outputs decoded combinationally from state, Reset and RCO.
- Reset (any state):
  - next state IDLE; Done=Tick=0; latched preset=0.
  - Clear_bar=0 while Reset is high, so the stage clears on the same edge.
- Preset P = (2^WIDTH − Length) mod 2^WIDTH, held in a register. D = P at all times.
- IDLE: Clear_bar=1, Load_bar=1, ENT=ENP=0, Busy=0.
  - Start=1 latches P and goes to LOAD. Otherwise stay.
- LOAD: Load_bar=0, ENT=ENP=0, Busy=1. The stage loads P on this edge.
  - Next state COUNT; Abort=1 instead goes to CLEAR.
- COUNT: ENT=1, ENP=~Hold, Busy=1.
  - Terminal edge = rising edge with RCO=1 and Hold=0.
  - At terminal edge with Reload=1: Load_bar=0 combinationally in that cycle, so the stage reloads P instead of wrapping. Stay in COUNT; Tick=1 next cycle. Period is exactly N clocks.
  - At terminal edge with Reload=0: Load_bar=1; the stage wraps to 0. Go to DONE; Done=Tick=1 next cycle.
  - Abort=1 overrides both and goes to CLEAR.
- DONE: ENT=ENP=0, Busy=0, Done=1, Tick=1 for exactly one cycle.
  - Next state IDLE; Start is ignored here.
- CLEAR: Clear_bar=0, ENT=ENP=0, Busy=1 for one cycle; next state IDLE. No Done, no Tick.
- Start is ignored outside IDLE. Abort is ignored in IDLE and DONE.
- Latency, one-shot, no Hold: Start sampled at edge E0 gives Done high in the cycle after edge E0+N+1.
  - Hold cycles add one each.
- Boundaries:
  - N=1: P = all ones; RCO is high on the first COUNT cycle, so the terminal edge is the first COUNT edge.
  - Length=0: P=0, interval of 2^WIDTH counts.
  - Hold=1 during the RCO=1 cycle: no terminal edge; the stage holds; RCO stays high.
  - Simultaneous Abort and terminal edge: Abort wins.
  - Reset mid-interval: IDLE on the next edge, stage cleared, no Done.

Test Plan:
- WIDTH=3, Reset 2 cycles, Start with Length=3, Reload=0: D=5 in LOAD; stage Q sequence 5,6,7,0; Done and Tick high one cycle, 4 edges after Start; Busy falls with Done.
- Length=3, Reload=1 held for 3 periods, then 0: Tick every 3 cycles, Q cycles 5,6,7,5,6,7; Load_bar low only in the RCO cycles; Done only after the final period.
- Length=1 and Length=0: Tick after 1 COUNT edge and after 8 COUNT edges respectively; D=7 and D=0.
- Hold high 3 cycles mid-count, including the RCO=1 cycle: Q frozen, RCO stays 1, Done delayed exactly 3 cycles.
- Abort in COUNT at Q=6: one CLEAR cycle with Clear_bar=0, stage Q=0, IDLE next, Done=Tick=0. Repeat with Abort on the terminal edge: still no Done.
- Reset asserted during COUNT, plus Start asserted while Busy: Reset gives Clear_bar=0, state IDLE, outputs idle. Start while Busy is ignored, with Length unchanged.
